// File: rtl/data_mem_lsu.sv
// RV32I data memory with request/response handshake, lane steering, load extension,
// fault reporting, a configurable response pipeline and an optional post-reset clear sweep.

`ifndef _MEM_ADDR_WIDTH_
`define _MEM_ADDR_WIDTH_ 32
`endif
`ifndef _MEM_DATA_WIDTH_
`define _MEM_DATA_WIDTH_ 32
`endif
`ifndef _DATA_MEM_SIZE_
`define _DATA_MEM_SIZE_ 1024
`endif

module data_mem_lsu #(
    parameter string MEM_INIT_FILE  = "",
    parameter int    MEM_ADDR_WIDTH = `_MEM_ADDR_WIDTH_,
    parameter int    DATA_WIDTH     = `_MEM_DATA_WIDTH_,
    parameter int    DATA_MEM_SIZE  = `_DATA_MEM_SIZE_,
    parameter int    READ_LATENCY   = 1,
    parameter bit    CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    // Both channels: a beat transfers on a rising edge where valid & ready are high.
    // A response holds data/err stable while valid is high and ready is low.
    input  logic                      i_ReqValid,
    output logic                      o_ReqReady,
    input  logic                      i_ReqWrite,
    input  logic [2:0]                i_ReqFunct3,
    input  logic [MEM_ADDR_WIDTH-1:0] i_ReqAddr,
    input  logic [DATA_WIDTH-1:0]     i_ReqWData,
    output logic                      o_RspValid,
    input  logic                      i_RspReady,
    output logic [DATA_WIDTH-1:0]     o_RspRData,
    output logic                      o_RspErr
);

    localparam int IDX_W  = MEM_ADDR_WIDTH - 2;
    localparam int MIDX_W = $clog2(DATA_MEM_SIZE);
    localparam logic [IDX_W:0]    SIZE_LIM = DATA_MEM_SIZE[IDX_W:0];
    localparam logic [MIDX_W-1:0] CLR_LAST = MIDX_W'(DATA_MEM_SIZE - 1);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                state, state_nxt;
    logic [MIDX_W-1:0]     clr_cnt, clr_cnt_nxt;
    logic                  clr_we;

    logic [DATA_WIDTH-1:0] mem [DATA_MEM_SIZE];

    logic [IDX_W-1:0]      word_idx;
    logic [MIDX_W-1:0]     mem_idx;
    logic [1:0]            lane;
    logic                  range_bad, align_bad, f3_bad, req_err;
    logic                  stall, accept, st_we;
    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] wdata_lane;
    logic [DATA_WIDTH-1:0] rd_word, load_data;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;

    logic                  stg_valid [READ_LATENCY];
    logic [DATA_WIDTH-1:0] stg_data  [READ_LATENCY];
    logic                  stg_err   [READ_LATENCY];

    // ---------------- clear / run sequencer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we      = ~reset;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == CLR_LAST) begin
                    state_nxt   = ST_RUN;
                    clr_cnt_nxt = '0;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // ---------------- request decode ----------------
    assign word_idx  = i_ReqAddr[MEM_ADDR_WIDTH-1:2];
    assign mem_idx   = word_idx[MIDX_W-1:0];
    assign lane      = i_ReqAddr[1:0];
    assign range_bad = {1'b0, word_idx} >= SIZE_LIM;

    always_comb begin
        f3_bad    = 1'b0;
        align_bad = 1'b0;
        case (i_ReqFunct3)
            F3_B, F3_BU: align_bad = 1'b0;
            F3_H, F3_HU: align_bad = i_ReqAddr[0];
            F3_W:        align_bad = |lane;
            default:     f3_bad    = 1'b1;
        endcase
        // Unsigned variants only exist for loads.
        if (i_ReqWrite && (i_ReqFunct3 == F3_BU || i_ReqFunct3 == F3_HU))
            f3_bad = 1'b1;
    end

    assign req_err    = range_bad | align_bad | f3_bad;
    assign stall      = o_RspValid & ~i_RspReady;
    assign o_ReqReady = (state == ST_RUN) & ~stall & ~reset;
    assign accept     = i_ReqValid & o_ReqReady;
    assign st_we      = accept & i_ReqWrite & ~req_err;

    // ---------------- store steering ----------------
    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = '0;
        case (i_ReqFunct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << lane;
                wdata_lane = {4{i_ReqWData[7:0]}};
            end
            2'b01: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{i_ReqWData[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                wdata_lane = i_ReqWData;
            end
        endcase
    end

    // Clear sweep owns the write port while active; requests are blocked then.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (st_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b])
                    mem[mem_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
        end
    end

    // ---------------- load extraction ----------------
    assign rd_word = mem[mem_idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = '0;
        case (i_ReqFunct3)
            F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
            F3_BU:   load_data = {24'h0, rd_byte};
            F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
            F3_HU:   load_data = {16'h0, rd_half};
            F3_W:    load_data = rd_word;
            default: load_data = '0;
        endcase
        if (i_ReqWrite || req_err)
            load_data = '0;
    end

    // ---------------- response pipeline ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stg_valid[i] <= 1'b0;
                stg_data[i]  <= '0;
                stg_err[i]   <= 1'b0;
            end
        end else if (!stall) begin
            stg_valid[0] <= accept;
            stg_data[0]  <= load_data;
            stg_err[0]   <= accept & req_err;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_data[i]  <= stg_data[i-1];
                stg_err[i]   <= stg_err[i-1];
            end
        end
    end

    assign o_RspValid = stg_valid[READ_LATENCY-1];
    assign o_RspRData = stg_data[READ_LATENCY-1];
    assign o_RspErr   = stg_err[READ_LATENCY-1];

endmodule
